// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store word requests onto one memory port.
// Data wins arbitration unless fetch has waited STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_IfReq,
    input  logic [ADDR_WIDTH-1:0] i_IfAddr,
    output logic [DATA_WIDTH-1:0] o_IfRdata,
    output logic                  o_IfValid,
    input  logic                  i_DReq,
    input  logic                  i_DWe,
    input  logic [ADDR_WIDTH-1:0] i_DAddr,
    input  logic [DATA_WIDTH-1:0] i_DWdata,
    output logic [DATA_WIDTH-1:0] o_DRdata,
    output logic                  o_DValid,
    output logic                  o_MemReq,
    output logic                  o_MemWe,
    output logic [ADDR_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0] o_MemWdata,
    input  logic                  i_MemAck,
    input  logic [DATA_WIDTH-1:0] i_MemRdata,
    output logic                  o_Busy
);
    typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, RESP} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  grant_d, grant_if, ack;
    logic                  mem_req_nxt, mem_we_nxt, if_valid_nxt, d_valid_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;

    assign grant_d  = state == IDLE && i_DReq && !(i_IfReq && cnt == LIMIT);
    assign grant_if = state == IDLE && i_IfReq && !grant_d;
    assign ack      = (state == IF_ACC || state == D_ACC) && i_MemAck;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            o_MemReq   <= 1'b0;
            o_MemWe    <= 1'b0;
            o_MemAddr  <= '0;
            o_MemWdata <= '0;
            o_IfValid  <= 1'b0;
            o_DValid   <= 1'b0;
            o_IfRdata  <= '0;
            o_DRdata   <= '0;
            o_Busy     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            o_MemReq   <= mem_req_nxt;
            o_MemWe    <= mem_we_nxt;
            o_MemAddr  <= mem_addr_nxt;
            o_MemWdata <= mem_wdata_nxt;
            o_IfValid  <= if_valid_nxt;
            o_DValid   <= d_valid_nxt;
            o_IfRdata  <= if_rdata_nxt;
            o_DRdata   <= d_rdata_nxt;
            o_Busy     <= state_nxt != IDLE;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:          state_nxt = grant_d ? D_ACC : grant_if ? IF_ACC : IDLE;
            IF_ACC, D_ACC: state_nxt = i_MemAck ? RESP : state;
            default:       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req_nxt   = o_MemReq;
        mem_we_nxt    = o_MemWe;
        mem_addr_nxt  = o_MemAddr;
        mem_wdata_nxt = o_MemWdata;
        if_rdata_nxt  = o_IfRdata;
        d_rdata_nxt   = o_DRdata;
        if_valid_nxt  = 1'b0;
        d_valid_nxt   = 1'b0;
        cnt_nxt       = cnt;
        if (grant_d || grant_if) begin
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = grant_d && i_DWe;
            mem_addr_nxt  = grant_d ? i_DAddr : i_IfAddr;
            mem_wdata_nxt = grant_d ? i_DWdata : '0;
            cnt_nxt       = (grant_d && i_IfReq) ? ((cnt == LIMIT) ? cnt : cnt + 4'd1) : '0;
        end
        if (ack) begin
            mem_req_nxt  = 1'b0;
            if_valid_nxt = state == IF_ACC;
            d_valid_nxt  = state == D_ACC;
            if_rdata_nxt = (state == IF_ACC) ? i_MemRdata : o_IfRdata;
            d_rdata_nxt  = (state == D_ACC && !o_MemWe) ? i_MemRdata : o_DRdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single accesses plus arbitration, starvation and reset
// sequences, checked against a grant/response scoreboard and a behavioural memory.
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        d;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
    } acc_t;

    typedef struct {
        logic        d;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
    } vec_t;

    logic        i_Clk = 1'b0, i_Rst = 1'b1;
    logic        i_IfReq, i_DReq, i_DWe, i_MemAck;
    logic [31:0] i_IfAddr, i_DAddr, i_DWdata, i_MemRdata;
    logic [31:0] o_IfRdata, o_DRdata, o_MemAddr, o_MemWdata;
    logic        o_IfValid, o_DValid, o_MemReq, o_MemWe, o_Busy;

    acc_t        if_q[$], d_q[$], g_q[$];
    vec_t        tbl[7];
    int          tests = 0, fails = 0, cycle = 0;
    int          ack_delay = 0, wait_left = 0, req_len = 0;
    int          grant_cyc = 0, if_vc = 0, d_vc = 0;
    logic        prev_req = 1'b0, force_ack = 1'b0;
    logic [64:0] held = '0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(2)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst),
        .i_IfReq(i_IfReq), .i_IfAddr(i_IfAddr), .o_IfRdata(o_IfRdata), .o_IfValid(o_IfValid),
        .i_DReq(i_DReq), .i_DWe(i_DWe), .i_DAddr(i_DAddr), .i_DWdata(i_DWdata),
        .o_DRdata(o_DRdata), .o_DValid(o_DValid),
        .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr), .o_MemWdata(o_MemWdata),
        .i_MemAck(i_MemAck), .i_MemRdata(i_MemRdata), .o_Busy(o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
    endfunction

    function automatic acc_t mk(input logic d, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
        return '{d: d, we: we, a: a, wd: wd, rd: rd};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    task automatic push_req(input acc_t e);
        if (e.d) d_q.push_back(e);
        else if_q.push_back(e);
    endtask

    task automatic drive_req();
        i_IfReq  = if_q.size() != 0;
        i_IfAddr = i_IfReq ? if_q[0].a : '0;
        i_DReq   = d_q.size() != 0;
        i_DWe    = i_DReq ? d_q[0].we : 1'b0;
        i_DAddr  = i_DReq ? d_q[0].a : '0;
        i_DWdata = i_DReq ? d_q[0].wd : '0;
    endtask

    task automatic cyc();
        acc_t e;
        @(posedge i_Clk);
        #1;
        cycle++;
        if (o_MemReq && !prev_req) begin
            if (g_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL grant: unexpected grant addr %0h (cycle %0d)", o_MemAddr, cycle);
            end else begin
                e = g_q.pop_front();
                chk("grant_addr", o_MemAddr, e.a);
                chk("grant_we", o_MemWe, e.we);
                chk("grant_wdata", o_MemWdata, e.d ? e.wd : 32'h0);
            end
            held      = {o_MemWe, o_MemAddr, o_MemWdata};
            wait_left = ack_delay;
            grant_cyc = cycle;
            req_len   = 0;
        end else if (o_MemReq) begin
            chk("req_stable", {o_MemWe, o_MemAddr, o_MemWdata}, held);
        end
        if (o_MemReq) req_len++;
        if (o_IfValid && o_DValid) chk("one_valid", {o_IfValid, o_DValid}, 2'b00);
        if (o_IfValid) begin
            if_vc = cycle;
            if (if_q.size() == 0) chk("if_valid_unexpected", o_IfValid, 1'b0);
            else begin
                e = if_q.pop_front();
                chk("if_rdata", o_IfRdata, e.rd);
            end
        end
        if (o_DValid) begin
            d_vc = cycle;
            if (d_q.size() == 0) chk("d_valid_unexpected", o_DValid, 1'b0);
            else begin
                e = d_q.pop_front();
                chk("d_rdata", o_DRdata, e.rd);
            end
        end
        prev_req = o_MemReq;
        if (o_MemReq && wait_left == 0) begin
            i_MemAck   = 1'b1;
            i_MemRdata = mem_of(o_MemAddr);
        end else begin
            i_MemAck   = force_ack;
            i_MemRdata = $urandom;
            if (o_MemReq) wait_left--;
        end
        drive_req();
    endtask

    task automatic drain();
        int k = 0;
        while ((if_q.size() != 0 || d_q.size() != 0 || g_q.size() != 0 || o_Busy) && k < 100) begin
            cyc();
            k++;
        end
        chk("drain_done", k < 100, 1'b1);
    endtask

    initial begin
        int start;
        acc_t e;
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0050_0093, 0};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h1000_EFFF, 0};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1000_EFFF, 3};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'h0104_FEFB, 2};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,         32'h2004_DFFB, 1};
        tbl[5] = '{1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 32'h2004_DFFB, 0};
        tbl[6] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,         32'h0200_FDFF, 0};

        // reset with random inputs
        for (int r = 0; r < 3; r++) begin
            {i_IfReq, i_DReq, i_DWe, i_MemAck} = 4'($urandom);
            i_IfAddr = $urandom; i_DAddr = $urandom; i_DWdata = $urandom; i_MemRdata = $urandom;
            @(posedge i_Clk);
            #1;
            chk("reset_outs", {o_IfRdata, o_IfValid, o_DRdata, o_DValid, o_MemReq, o_MemWe,
                               o_MemAddr, o_MemWdata, o_Busy}, '0);
        end
        drive_req();
        i_MemAck = 1'b0;
        i_MemRdata = '0;
        i_Rst = 1'b0;
        force_ack = 1'b1;
        for (int r = 0; r < 3; r++) begin
            cyc();
            chk("idle_no_req", {o_MemReq, o_Busy, o_IfValid, o_DValid}, 4'b0);
        end
        force_ack = 1'b0;

        // single accesses from the table
        for (int r = 0; r < 7; r++) begin
            e = mk(tbl[r].d, tbl[r].we, tbl[r].a, tbl[r].wd, tbl[r].rd);
            ack_delay = tbl[r].dly;
            start = cycle;
            push_req(e);
            g_q.push_back(e);
            drive_req();
            drain();
            chk("grant_lat", grant_cyc - start, 1);
            chk("valid_lat", (tbl[r].d ? d_vc : if_vc) - start, 2 + tbl[r].dly);
            chk("req_len", req_len, tbl[r].dly + 1);
        end

        // simultaneous requests: data first, fetch after
        ack_delay = 0;
        start = cycle;
        push_req(mk(1'b0, 1'b0, 32'h200, 32'h0, 32'h0200_FDFF));
        push_req(mk(1'b1, 1'b0, 32'h1000, 32'h0, 32'h1000_EFFF));
        g_q.push_back(mk(1'b1, 1'b0, 32'h1000, 32'h0, 32'h0));
        g_q.push_back(mk(1'b0, 1'b0, 32'h200, 32'h0, 32'h0));
        drive_req();
        drain();
        chk("simul_d_valid", d_vc - start, 2);
        chk("simul_if_grant", grant_cyc - start, 4);
        chk("simul_if_valid", if_vc - start, 5);

        // starvation with limit 2: D, D, I, D, D, I
        push_req(mk(1'b1, 1'b0, 32'h1000, 32'h0, 32'h1000_EFFF));
        push_req(mk(1'b1, 1'b0, 32'h1004, 32'h0, 32'h1004_EFFB));
        push_req(mk(1'b1, 1'b0, 32'h1008, 32'h0, 32'h1008_EFF7));
        push_req(mk(1'b1, 1'b0, 32'h100C, 32'h0, 32'h100C_EFF3));
        push_req(mk(1'b0, 1'b0, 32'h200, 32'h0, 32'h0200_FDFF));
        push_req(mk(1'b0, 1'b0, 32'h204, 32'h0, 32'h0204_FDFB));
        g_q.push_back(mk(1'b1, 1'b0, 32'h1000, 32'h0, 32'h0));
        g_q.push_back(mk(1'b1, 1'b0, 32'h1004, 32'h0, 32'h0));
        g_q.push_back(mk(1'b0, 1'b0, 32'h200, 32'h0, 32'h0));
        g_q.push_back(mk(1'b1, 1'b0, 32'h1008, 32'h0, 32'h0));
        g_q.push_back(mk(1'b1, 1'b0, 32'h100C, 32'h0, 32'h0));
        g_q.push_back(mk(1'b0, 1'b0, 32'h204, 32'h0, 32'h0));
        drive_req();
        drain();

        // reset during the second data access, counter at the limit
        push_req(mk(1'b1, 1'b0, 32'h1010, 32'h0, 32'h1010_EFEF));
        push_req(mk(1'b1, 1'b0, 32'h1014, 32'h0, 32'h1014_EFEB));
        push_req(mk(1'b0, 1'b0, 32'h208, 32'h0, 32'h0208_FDF7));
        g_q.push_back(mk(1'b1, 1'b0, 32'h1010, 32'h0, 32'h0));
        g_q.push_back(mk(1'b1, 1'b0, 32'h1014, 32'h0, 32'h0));
        drive_req();
        for (int k = 0; k < 40 && g_q.size() != 0; k++) cyc();
        chk("rst_mid_in_access", o_MemReq, 1'b1);
        #2;
        i_Rst = 1'b1;
        #1;
        chk("rst_mid_outs", {o_MemReq, o_Busy, o_DValid, o_IfValid}, 4'b0);
        i_MemAck = 1'b0;
        e = d_q.pop_front();
        push_req(mk(1'b1, 1'b0, 32'h1018, 32'h0, 32'h1018_EFE7));
        drive_req();
        @(posedge i_Clk);
        #1;
        chk("rst_mid_hold", {o_MemReq, o_Busy, o_DValid, o_IfValid}, 4'b0);
        i_Rst = 1'b0;
        prev_req = 1'b0;
        g_q.push_back(mk(1'b1, 1'b0, 32'h1018, 32'h0, 32'h0));
        g_q.push_back(mk(1'b0, 1'b0, 32'h208, 32'h0, 32'h0));
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
